// File: rtl/mds_fetch_ctrl.sv
// mds_fetch_ctrl
// Fetches the MDS coefficient set for the selected cipher mode from the
// coefficient RAM and hands it to the diffusion datapath as 64-bit beats.
// Each beat is two consecutive 32-bit RAM words: the even word goes in the
// high half and the odd word in the low half. Every beat is held under a
// valid/ready handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, alg_mode     fetch request and cipher mode (sampled in IDLE only)
//   flush               synchronous abort back to IDLE
//   ram_en, ram_addr    single-cycle RAM read request (addr is 0 when idle)
//   ram_data            RAM read data, valid the cycle after ram_en
//   mds_out, mds_valid  packed beat and its valid flag
//   mds_ready           consumer accepts the beat
//   busy, done, err     status: not idle / last beat taken / bad mode
//
// state  | meaning
// IDLE   | waiting for start
// RD_HI  | read request for even word
// RD_LO  | even word arrives into hi_q, read request for odd word
// CAP    | odd word arrives, beat loaded into mds_out
// OUT    | beat held until mds_ready
// DONE   | one-cycle done pulse, then IDLE
module mds_fetch_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        alg_mode,
  input  logic              flush,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_data,
  output logic [63:0]       mds_out,
  output logic              mds_valid,
  input  logic              mds_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HI,
    S_RD_LO,
    S_CAP,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        words_q, words_d;
  logic [4:0]        word_cnt_q, word_cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [63:0]       mds_out_q, mds_out_d;
  logic              mds_valid_q, mds_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] mode_base;
  logic [4:0]        mode_words;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    mode_base  = '0;
    mode_words = 5'd0;
    case (alg_mode)
      3'd0: begin mode_base = ADDR_W'(8'h00); mode_words = 5'd2;  end
      3'd1: begin mode_base = ADDR_W'(8'h10); mode_words = 5'd4;  end
      3'd2: begin mode_base = ADDR_W'(8'h20); mode_words = 5'd8;  end
      3'd3: begin mode_base = ADDR_W'(8'h40); mode_words = 5'd16; end
      default: ;
    endcase
  end

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign rd_addr = base_q + ADDR_W'(word_cnt_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    words_d     = words_q;
    word_cnt_d  = word_cnt_q;
    hi_d        = hi_q;
    mds_out_d   = mds_out_q;
    mds_valid_d = mds_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ram_en      = 1'b0;
    ram_addr    = '0;

    // flush wins over everything, including the read strobe of this cycle.
    if (flush) begin
      state_d     = S_IDLE;
      mds_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (alg_mode[2]) begin
              err_d = 1'b1;
            end else begin
              base_d     = mode_base;
              words_d    = mode_words;
              word_cnt_d = 5'd0;
              state_d    = S_RD_HI;
            end
          end
        end
        S_RD_HI: begin
          ram_en   = 1'b1;
          ram_addr = rd_addr;
          state_d  = S_RD_LO;
        end
        S_RD_LO: begin
          hi_d     = ram_data;
          ram_en   = 1'b1;
          ram_addr = rd_addr + ADDR_W'(1);
          state_d  = S_CAP;
        end
        S_CAP: begin
          mds_out_d   = {hi_q, ram_data};
          mds_valid_d = 1'b1;
          word_cnt_d  = word_cnt_q + 5'd2;
          state_d     = S_OUT;
        end
        S_OUT: begin
          if (mds_ready) begin
            mds_valid_d = 1'b0;
            // word_cnt_q already counts the beat being accepted.
            if (word_cnt_q == words_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_RD_HI;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      words_q     <= 5'd0;
      word_cnt_q  <= 5'd0;
      hi_q        <= 32'd0;
      mds_out_q   <= 64'd0;
      mds_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      words_q     <= words_d;
      word_cnt_q  <= word_cnt_d;
      hi_q        <= hi_d;
      mds_out_q   <= mds_out_d;
      mds_valid_q <= mds_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mds_out   = mds_out_q;
  assign mds_valid = mds_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
